decay_scheduler: RTL and testbench

- Time-multiplexes one shared `potential_decay` unit across NUM_NEURONS membrane potentials held in an external potential memory.
- On each `time_step` pulse it sweeps all neurons in index order: read potential, load it into the decay unit with that neuron's mode, wait the unit's latency, write the result back.
- Holds a per-neuron decay-mode table that software configures.
- Sits between the time-step generator, the neuron potential RAM and the decay datapath.

---
 rtl/decay_pkg.sv | 19 +
 rtl/decay_mode_table.sv | 34 +++
 rtl/decay_scheduler.sv | 176 +++++++++++++++++
 tb/tb_decay_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decay_pkg.sv
// Shared types and constants for the decay scheduler: FSM state encoding,
// decay-mode width and the reserved mode values.
package decay_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_BYPASS  = 3'b000;
  localparam logic [MODE_W-1:0] MODE_DEFAULT = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LOAD,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/decay_mode_table.sv
// Per-neuron decay-mode register file: one synchronous write port, one
// combinational read port, every entry reset to DEFAULT_MODE.
module decay_mode_table
  import decay_pkg::*;
#(
  parameter int                NUM_NEURONS  = 32,
  parameter int                IDX_W        = $clog2(NUM_NEURONS),
  parameter logic [MODE_W-1:0] DEFAULT_MODE = MODE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [MODE_W-1:0] wr_mode,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [MODE_W-1:0] rd_mode
);

  logic [MODE_W-1:0] tbl [NUM_NEURONS];

  // Writes to indices beyond the table are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        tbl[i] <= DEFAULT_MODE;
      end
    end else if (we && (32'(wr_idx) < NUM_NEURONS)) begin
      tbl[wr_idx] <= wr_mode;
    end
  end

  assign rd_mode = tbl[rd_idx];

endmodule

// File: rtl/decay_scheduler.sv
// Sweeps all neuron potentials through one shared decay unit on every
// time_step: read from RAM, load the unit, wait its latency, write back.
module decay_scheduler
  import decay_pkg::*;
#(
  parameter int                NUM_NEURONS   = 32,
  parameter int                DATA_W        = 32,
  parameter int                DECAY_LATENCY = 2,
  parameter logic [MODE_W-1:0] DEFAULT_MODE  = MODE_DEFAULT,
  localparam int               IDX_W         = $clog2(NUM_NEURONS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              time_step,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [MODE_W-1:0] cfg_mode,
  output logic              mem_rd_en,
  output logic [IDX_W-1:0]  mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [IDX_W-1:0]  mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              du_load,
  output logic [MODE_W-1:0] du_mode,
  output logic [DATA_W-1:0] du_potential,
  input  logic [DATA_W-1:0] du_result,
  output logic              busy,
  output logic              sweep_done,
  output logic              overrun,
  input  logic              clear_overrun,
  output logic [IDX_W-1:0]  cur_idx
);

  localparam int               CNT_W     = $clog2(DECAY_LATENCY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(DECAY_LATENCY - 1);

  state_t            state, state_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_next;
  logic              overrun_q;
  logic [MODE_W-1:0] cur_mode;

  logic [IDX_W-1:0]  rd_addr_q, wr_addr_q;
  logic [DATA_W-1:0] wr_data_q, pot_q;
  logic [MODE_W-1:0] mode_q;

  decay_mode_table #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W),
    .DEFAULT_MODE(DEFAULT_MODE)
  ) u_mode_table (
    .clk    (clk),
    .rst    (rst),
    .we     (cfg_we),
    .wr_idx (cfg_idx),
    .wr_mode(cfg_mode),
    .rd_idx (idx),
    .rd_mode(cur_mode)
  );

  // Data outputs drive live values in their active state and otherwise fall
  // back to the registered copy of what was last presented.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    wait_cnt_next = wait_cnt;
    mem_rd_en     = 1'b0;
    mem_wr_en     = 1'b0;
    du_load       = 1'b0;
    sweep_done    = 1'b0;
    mem_rd_addr   = rd_addr_q;
    mem_wr_addr   = wr_addr_q;
    mem_wr_data   = wr_data_q;
    du_potential  = pot_q;
    du_mode       = mode_q;

    case (state)
      ST_IDLE: begin
        idx_next = '0;
        if (time_step && enable) begin
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        if (cur_mode == MODE_BYPASS) begin
          if (idx == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end else begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = idx;
          state_next  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        du_load       = 1'b1;
        du_potential  = mem_rd_data;
        du_mode       = cur_mode;
        wait_cnt_next = WAIT_INIT;
        state_next    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          state_next = ST_WRITE;
        end else begin
          wait_cnt_next = wait_cnt - CNT_W'(1);
        end
      end
      ST_WRITE: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = idx;
        mem_wr_data = du_result;
        if (idx == LAST_IDX) begin
          state_next = ST_DONE;
        end else begin
          idx_next   = idx + IDX_W'(1);
          state_next = ST_READ;
        end
      end
      ST_DONE: begin
        sweep_done = 1'b1;
        idx_next   = '0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // A time_step arriving mid-sweep is only recorded; setting beats clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      overrun_q <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pot_q     <= '0;
      mode_q    <= '0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      wait_cnt <= wait_cnt_next;
      if (time_step && (state != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end else if (clear_overrun) begin
        overrun_q <= 1'b0;
      end
      if (mem_rd_en) begin
        rd_addr_q <= mem_rd_addr;
      end
      if (mem_wr_en) begin
        wr_addr_q <= mem_wr_addr;
        wr_data_q <= mem_wr_data;
      end
      if (du_load) begin
        pot_q  <= du_potential;
        mode_q <= du_mode;
      end
    end
  end

  assign busy    = (state != ST_IDLE);
  assign overrun = overrun_q;
  assign cur_idx = idx;

endmodule

// File: tb/tb_decay_scheduler.sv
// Bench for decay_scheduler: RAM and decay-unit models around the DUT, a
// reference sweep model feeding read/write scoreboards, and directed plus random sweeps.
module tb_decay_scheduler;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int IW  = 2;
  localparam int MW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          time_step = 1'b0;
  logic          enable = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [MW-1:0] cfg_mode = '0;
  logic          clear_overrun = 1'b0;
  logic          mem_rd_en, mem_wr_en, du_load, busy, sweep_done, overrun;
  logic [IW-1:0] mem_rd_addr, mem_wr_addr, cur_idx;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] mem_wr_data, du_potential, du_result;
  logic [MW-1:0] du_mode;

  always #5 clk = ~clk;

  decay_scheduler #(
    .NUM_NEURONS  (N),
    .DATA_W       (DW),
    .DECAY_LATENCY(LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .time_step    (time_step),
    .enable       (enable),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_mode     (cfg_mode),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .du_load      (du_load),
    .du_mode      (du_mode),
    .du_potential (du_potential),
    .du_result    (du_result),
    .busy         (busy),
    .sweep_done   (sweep_done),
    .overrun      (overrun),
    .clear_overrun(clear_overrun),
    .cur_idx      (cur_idx)
  );

  // Potential RAM with one-cycle read latency; preload requests come from the bench.
  logic [DW-1:0] ram     [N];
  logic [DW-1:0] pre_ram [N];
  logic          do_load = 1'b0;

  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < N; i++) ram[i] <= pre_ram[i];
    end else if (mem_wr_en) begin
      ram[mem_wr_addr] <= mem_wr_data;
    end
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
  end

  // Decay unit: result = p - (p >> mode), valid LAT cycles after du_load and held.
  logic [DW-1:0] dly0 = '0;
  logic [DW-1:0] dly1 = '0;
  always @(posedge clk) begin
    if (du_load) dly0 <= du_potential - (du_potential >> du_mode);
    dly1 <= dly0;
  end
  assign du_result = dly1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_wr[$];
  int            exp_rd[$];
  logic [DW-1:0] model_ram  [N];
  logic [MW-1:0] model_mode [N];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic reportUnexpected(input string name, input int addr);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got strobe at address %0d, expected none", name, addr);
  endtask

  // Scoreboard monitor: every RAM strobe is matched against the reference model.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (mem_rd_en) begin
      if (exp_rd.size() == 0) reportUnexpected("unexpected_read", int'(mem_rd_addr));
      else checkOutput("read_addr", 64'(mem_rd_addr), 64'(exp_rd.pop_front()));
    end
    if (mem_wr_en) begin
      if (exp_wr.size() == 0) reportUnexpected("unexpected_write", int'(mem_wr_addr));
      else begin
        e = exp_wr.pop_front();
        checkOutput("write_addr", 64'(mem_wr_addr), 64'(e.addr));
        checkOutput("write_data", 64'(mem_wr_data), 64'(e.data));
      end
    end
  end

  // Reference sweep: neurons in order, bypass costs one cycle, others 3+LAT.
  function automatic int modelSweep();
    int cyc = 1;
    for (int i = 0; i < N; i++) begin
      if (model_mode[i] == 0) begin
        cyc += 1;
      end else begin
        logic [DW-1:0] r;
        r = model_ram[i] - (model_ram[i] >> model_mode[i]);
        exp_rd.push_back(i);
        exp_wr.push_back('{addr: i, data: r});
        model_ram[i] = r;
        cyc += 3 + LAT;
      end
    end
    return cyc;
  endfunction

  task automatic preload(input logic [DW-1:0] a, b, c, d);
    @(negedge clk);
    pre_ram[0] = a; pre_ram[1] = b; pre_ram[2] = c; pre_ram[3] = d;
    for (int i = 0; i < N; i++) model_ram[i] = pre_ram[i];
    do_load = 1'b1;
    @(negedge clk);
    do_load = 1'b0;
  endtask

  task automatic setMode(input int i, input logic [MW-1:0] m);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = IW'(i); cfg_mode = m;
    @(negedge clk);
    cfg_we = 1'b0;
    model_mode[i] = m;
  endtask

  task automatic checkRam(input string tag);
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("%s_ram%0d", tag, i), 64'(ram[i]), 64'(model_ram[i]));
  endtask

  // One sweep; cycle k is the k-th cycle after the edge that samples time_step.
  task automatic applyStimulus(input string tag, input int ts_at, input int clr_at,
                               input int en_drop_at, input int cfg_at,
                               input logic [IW-1:0] ci, input logic [MW-1:0] cm);
    int exp_cyc, done_k, busy_k, idle_busy;
    exp_cyc = modelSweep();
    done_k = -1;
    busy_k = 0;
    @(negedge clk);
    enable = 1'b1;
    time_step = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (ts_at > 0 && k == ts_at + 1) checkOutput({tag, "_overrun_set"}, 64'(overrun), 64'd1);
      else if (clr_at > 0 && k == clr_at + 1) checkOutput({tag, "_overrun_clr"}, 64'(overrun), 64'd0);
      if (busy) busy_k++;
      time_step = (k == ts_at);
      clear_overrun = (k == clr_at);
      if (k == en_drop_at) enable = 1'b0;
      cfg_we = (k == cfg_at);
      cfg_idx = ci;
      cfg_mode = cm;
      if (sweep_done) begin
        done_k = k;
        break;
      end
    end
    time_step = 1'b0; clear_overrun = 1'b0; cfg_we = 1'b0; enable = 1'b1;
    checkOutput({tag, "_done_cycle"}, 64'(done_k), 64'(exp_cyc));
    checkOutput({tag, "_busy_cycles"}, 64'(busy_k), 64'(exp_cyc));
    idle_busy = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) idle_busy++;
    end
    checkOutput({tag, "_idle_after"}, 64'(idle_busy), 64'd0);
    checkOutput({tag, "_idx_idle"}, 64'(cur_idx), 64'd0);
    checkOutput({tag, "_sb_drained"}, 64'(exp_wr.size() + exp_rd.size()), 64'd0);
    checkRam(tag);
  endtask

  initial begin
    int quiet;
    for (int i = 0; i < N; i++) model_mode[i] = 3'b001;

    repeat (3) @(negedge clk);
    checkOutput("reset_strobes", 64'({mem_rd_en, mem_wr_en, du_load, busy, sweep_done, overrun}), 64'd0);
    checkOutput("reset_data", 64'({du_potential, du_mode, cur_idx}), 64'd0);
    rst = 1'b0;

    $display("[TB] Scenario 1: all modes 001");
    preload(1000, 2000, 3000, 4000);
    applyStimulus("s1", 0, 0, 0, 0, '0, '0);

    $display("[TB] Scenario 2: bypass idx 1 and 3");
    setMode(1, 3'b000);
    setMode(3, 3'b000);
    preload(1000, 2000, 3000, 4000);
    applyStimulus("s2", 0, 0, 0, 0, '0, '0);
    setMode(1, 3'b001);
    setMode(3, 3'b001);

    $display("[TB] Scenario 3: overrun");
    preload(1000, 2000, 3000, 4000);
    applyStimulus("s3a", 8, 0, 0, 0, '0, '0);
    applyStimulus("s3b", 0, 3, 0, 0, '0, '0);
    applyStimulus("s3c", 5, 5, 0, 0, '0, '0);

    $display("[TB] Scenario 4: reset during WAIT of neuron 2");
    setMode(3, 3'b101);
    preload(1000, 2000, 3000, 4000);
    exp_rd.push_back(0); exp_rd.push_back(1); exp_rd.push_back(2);
    exp_wr.push_back('{addr: 0, data: 500});
    exp_wr.push_back('{addr: 1, data: 1000});
    model_ram[0] = 500; model_ram[1] = 1000;
    @(negedge clk);
    time_step = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      time_step = 1'b0;
    end
    checkOutput("s4_pre_reset_idx", 64'(cur_idx), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("s4_strobes", 64'({mem_rd_en, mem_wr_en, du_load, busy, sweep_done, overrun}), 64'd0);
    checkOutput("s4_data", 64'({du_potential, mem_wr_data}), 64'd0);
    checkOutput("s4_addr_mode", 64'({du_mode, cur_idx, mem_rd_addr, mem_wr_addr}), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) model_mode[i] = 3'b001;
    repeat (3) @(negedge clk);
    checkOutput("s4_sb_drained", 64'(exp_wr.size() + exp_rd.size()), 64'd0);
    checkRam("s4");
    applyStimulus("s4_post", 0, 0, 0, 0, '0, '0);

    $display("[TB] Scenario 5: enable gating");
    preload(1000, 2000, 3000, 4000);
    @(negedge clk);
    enable = 1'b0; time_step = 1'b1;
    @(negedge clk);
    time_step = 1'b0;
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) quiet++;
    end
    checkOutput("s5_disabled_busy", 64'(quiet), 64'd0);
    applyStimulus("s5", 0, 0, 5, 0, '0, '0);

    $display("[TB] Scenario 6: cfg write during LOAD of idx 2");
    preload(1000, 2000, 3000, 4000);
    applyStimulus("s6a", 0, 0, 0, 12, 2'd2, 3'b010);
    model_mode[2] = 3'b010;
    applyStimulus("s6b", 0, 0, 0, 0, '0, '0);

    $display("[TB] Random sweeps");
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < N; i++) setMode(i, MW'($urandom_range(0, 7)));
      preload($urandom, $urandom, $urandom, $urandom);
      applyStimulus($sformatf("rnd%0d", it), ($urandom_range(0, 1) == 1) ? 2 : 0, 0, 0, 0, '0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
